// File: rtl/dsp_pkg.sv
// Shared types and helpers for the DSP48A1 result collector.
// The optional clamp helper is only used when DSP_PCOL_SAT_EN is defined.
package dsp_pkg;
  localparam int P_W   = 48;
  localparam int SAT_W = 32;

  typedef struct packed {
    logic [P_W-1:0] data;
    logic           carry;
    logic           sat;
  } dsp_res_t;

  // Clamp a signed 48-bit value into signed 32-bit range, sign-extended back to 48 bits.
  function automatic dsp_res_t sat48to32(input logic [P_W-1:0] p, input logic c);
    dsp_res_t r;
    r.data  = p;
    r.carry = c;
    r.sat   = 1'b0;
    if (p[P_W-1:SAT_W-1] != {(P_W-SAT_W+1){p[P_W-1]}}) begin
      r.sat  = 1'b1;
      r.data = p[P_W-1] ? {{(P_W-SAT_W+1){1'b1}}, {(SAT_W-1){1'b0}}}
                        : {{(P_W-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
    end
    return r;
  endfunction
endpackage

// File: rtl/dsp_res_fifo.sv
// First-word-fall-through FIFO of dsp_res_t with occupancy output.
// Head fields read as zero while empty so outputs are clean out of reset.
module dsp_res_fifo
  import dsp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  dsp_res_t                 wdata_i,
  input  logic                     pop_i,
  output dsp_res_t                 rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  dsp_res_t      mem_q [DEPTH];
  logic          do_pop;

  // Pop at empty is dropped, so a push into an empty FIFO always lands.
  assign do_pop = pop_i & (level_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (do_pop) rptr_d = rptr_q + 1'b1;
    case ({push_i, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign valid_o = (level_q != '0);
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign level_o = level_q;
endmodule

// File: rtl/dsp_p_collector.sv
// Result collector for the DSP48A1 slice: in-flight tracker, credit gate, FWFT buffer.
// Define DSP_PCOL_SAT_EN to clamp P into signed 32-bit range before buffering.
module dsp_p_collector
  import dsp_pkg::*;
#(
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic                   PCLK,
  input  logic                   PRST,
  input  logic                   PCE,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [P_W-1:0]         P,
  input  logic                   CARRYOUTOUT,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_W-1:0]         out_data,
  output logic                   out_carry,
  output logic                   out_sat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_drop
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [LAT-1:0] trk_q, trk_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic           err_q, err_d;
  logic           accept, pop, capture;
  dsp_res_t       wr_res, head;

  assign in_ready = (credits_q != '0);
  assign accept   = in_valid & in_ready & PCE;
  assign pop      = out_valid & out_ready;
  assign capture  = PCE & trk_q[LAT-1];

  if (LAT == 1) begin : g_trk1
    assign trk_d = PCE ? accept : trk_q;
  end else begin : g_trkn
    assign trk_d = PCE ? {trk_q[LAT-2:0], accept} : trk_q;
  end

  // Credits + in-flight + level stays equal to DEPTH, so the FIFO cannot overflow.
  always_comb begin
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
    err_d = err_q | (in_valid & ~in_ready);
  end

  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      trk_q     <= '0;
      credits_q <= CW'(DEPTH);
      err_q     <= 1'b0;
    end else begin
      trk_q     <= trk_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

`ifdef DSP_PCOL_SAT_EN
  assign wr_res = sat48to32(P, CARRYOUTOUT);
`else
  assign wr_res = '{data: P, carry: CARRYOUTOUT, sat: 1'b0};
`endif

  dsp_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (PCLK),
    .rst_i   (PRST),
    .push_i  (capture),
    .wdata_i (wr_res),
    .pop_i   (out_ready),
    .rdata_o (head),
    .valid_o (out_valid),
    .level_o (level)
  );

  // sat is only ever written as 0 when the clamp is compiled out.
  assign out_data  = head.data;
  assign out_carry = head.carry;
  assign out_sat   = head.sat;
  assign err_drop  = err_q;
endmodule

// File: tb/tb_dsp_p_collector.sv
// Directed bench for dsp_p_collector (LAT=4, DEPTH=8); sat checks follow DSP_PCOL_SAT_EN.
module tb_dsp_p_collector;
  logic        PCLK = 1'b0;
  logic        PRST, PCE, in_valid, in_ready, CARRYOUTOUT;
  logic        out_valid, out_ready, out_carry, out_sat, err_drop;
  logic [47:0] P, out_data;
  logic [3:0]  level;
  int total = 0;
  int bad   = 0;

  always #5 PCLK = ~PCLK;

  dsp_p_collector #(.LAT(4), .DEPTH(8)) dut (
    .PCLK(PCLK), .PRST(PRST), .PCE(PCE), .in_valid(in_valid), .in_ready(in_ready),
    .P(P), .CARRYOUTOUT(CARRYOUTOUT), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry), .out_sat(out_sat), .level(level),
    .err_drop(err_drop)
  );

  always @(negedge PCLK) begin
    if (PRST === 1'b0 && level > 4'd8) begin
      bad++;
      $display("FAIL level_bound got=%0d max=8", level);
    end
  end

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset;
    PRST = 1'b1; PCE = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    P = '0; CARRYOUTOUT = 1'b0;
    #3;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (out_data !== 48'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if ({out_carry, out_sat, err_drop} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {out_carry, out_sat, err_drop}); end
    tick; tick;
    PRST = 1'b0;
    tick;
  endtask

  task automatic test_latency;
    total++; if (err_drop !== 1'b0) begin bad++; $display("FAIL lat_err_clear got=%b want=0", err_drop); end
    in_valid = 1'b1; P = 48'hBAD;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%b want=0", out_valid); end
    P = 48'h1234; CARRYOUTOUT = 1'b1;
    tick;
    P = 48'hBAD; CARRYOUTOUT = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 48'h1234) begin bad++; $display("FAIL lat_data got=%h want=1234", out_data); end
    total++; if (out_carry !== 1'b1) begin bad++; $display("FAIL lat_carry got=%b want=1", out_carry); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL lat_level got=%0d want=1", level); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL lat_pop got=%b/%0d want=0/0", out_valid, level); end
  endtask

  task automatic test_fill;
    int acc = 0;
    logic [47:0] q[$];
    logic [47:0] exp_q[8];
    in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (in_ready) acc++;
      tick;
      P = 48'h5000 + 48'(i);
    end
    total++; if (acc != 8) begin bad++; $display("FAIL fill_accepts got=%0d want=8", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    total++; if (level !== 4'd8) begin bad++; $display("FAIL fill_level got=%0d want=8", level); end
    total++; if (err_drop !== 1'b1) begin bad++; $display("FAIL fill_err_drop got=%b want=1", err_drop); end
    total++; if (out_data !== 48'h5004) begin bad++; $display("FAIL fill_head got=%h want=5004", out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL credit_return got=%b want=1", in_ready); end
    total++; if (level !== 4'd7) begin bad++; $display("FAIL pop_level got=%0d want=7", level); end
    total++; if (out_data !== 48'h5005) begin bad++; $display("FAIL pop_head got=%h want=5005", out_data); end
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL credit_reuse got=%b want=0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) q.push_back(out_data);
      tick;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) exp_q[i] = 48'h5005 + 48'(i);
    exp_q[7] = 48'h5010;
    total++; if (q.size() != 8) begin bad++; $display("FAIL drain_count got=%0d want=8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      total++; if (q[i] !== exp_q[i]) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, q[i], exp_q[i]); end
    end
    total++; if (level !== 4'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL drain_end got=%0d/%b want=0/1", level, in_ready); end
  endtask

  task automatic test_stall;
    PCE = 1'b1; in_valid = 1'b1; P = 48'hBAD;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    PCE = 1'b0; P = 48'hDEAD;
    tick; tick; tick;
    total++; if (level !== 4'd0) begin bad++; $display("FAIL stall_no_write got=%0d want=0", level); end
    PCE = 1'b1; P = 48'hCAFE;
    tick;
    P = 48'hBAD;
    total++; if (level !== 4'd1) begin bad++; $display("FAIL stall_level got=%0d want=1", level); end
    total++; if (out_data !== 48'hCAFE) begin bad++; $display("FAIL stall_data got=%h want=cafe", out_data); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    PCE = 1'b0; in_valid = 1'b1;
    tick;
    PCE = 1'b1; in_valid = 1'b0;
    repeat (6) tick;
    total++; if (level !== 4'd0) begin bad++; $display("FAIL no_pce_issue got=%0d want=0", level); end
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    logic [47:0] q[$];
    logic [47:0] e;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      P = 48'h6000 + 48'(i);
    end
    total++; if (level !== 4'd8) begin bad++; $display("FAIL b2b_full got=%0d want=8", level); end
    out_ready = 1'b1;
    for (int i = 13; i <= 52; i++) begin
      if (in_valid && in_ready) acc++;
      if (out_valid) q.push_back(out_data);
      tick;
      P = 48'h6000 + 48'(i);
    end
    total++; if (acc != 39) begin bad++; $display("FAIL b2b_accepts got=%0d want=39", acc); end
    total++; if (q.size() != 40) begin bad++; $display("FAIL b2b_pops got=%0d want=40", q.size()); end
    for (int k = 0; k < q.size(); k++) begin
      e = (k < 8) ? 48'h6004 + 48'(k) : 48'h6011 + 48'(k - 8);
      total++; if (q[k] !== e) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", k, q[k], e); end
    end
    in_valid = 1'b0;
    repeat (10) tick;
    out_ready = 1'b0;
    total++; if (level !== 4'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain got=%0d/%b want=0/1", level, in_ready); end
  endtask

  task automatic test_err_drop;
    total++; if (err_drop !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err_drop); end
    in_valid = 1'b1;
    tick; tick;
    in_valid = 1'b0;
    repeat (4) tick;
    PRST = 1'b1;
    #2;
    total++; if (err_drop !== 1'b0) begin bad++; $display("FAIL err_reset got=%b want=0", err_drop); end
    total++; if (level !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_state got=%0d/%b/%b want=0/0/1", level, out_valid, in_ready); end
    tick;
    PRST = 1'b0;
    repeat (6) tick;
    total++; if (level !== 4'd0 || err_drop !== 1'b0) begin bad++; $display("FAIL midrst_after got=%0d/%b want=0/0", level, err_drop); end
  endtask

  task automatic test_sat;
    logic [47:0] vals[3];
    logic [47:0] exp_d[3];
    logic        exp_s[3];
    vals[0] = 48'h0001_0000_0000;
    vals[1] = 48'hFFFF_FFFF_FFF0;
    vals[2] = 48'hFFFF_0000_0000;
`ifdef DSP_PCOL_SAT_EN
    exp_d[0] = 48'h0000_7FFF_FFFF; exp_s[0] = 1'b1;
    exp_d[1] = 48'hFFFF_FFFF_FFF0; exp_s[1] = 1'b0;
    exp_d[2] = 48'hFFFF_8000_0000; exp_s[2] = 1'b1;
`else
    for (int k = 0; k < 3; k++) begin exp_d[k] = vals[k]; exp_s[k] = 1'b0; end
`endif
    P = '0; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (i == 3) in_valid = 1'b0;
      P = (i >= 4 && i <= 6) ? vals[i-4] : 48'h0;
    end
    total++; if (level !== 4'd3) begin bad++; $display("FAIL sat_level got=%0d want=3", level); end
    for (int k = 0; k < 3; k++) begin
      total++; if (out_data !== exp_d[k]) begin bad++; $display("FAIL sat_data[%0d] got=%h want=%h", k, out_data, exp_d[k]); end
      total++; if (out_sat !== exp_s[k]) begin bad++; $display("FAIL sat_flag[%0d] got=%b want=%b", k, out_sat, exp_s[k]); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_fill;
    test_stall;
    test_back_to_back;
    test_err_drop;
    test_sat;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
